// File: rtl/jtag_host_pkg.sv
// rtl/jtag_host_pkg.sv - op encodings, TAP walk constants and FSM state for the JTAG host engine
package jtag_host_pkg;

    typedef enum logic [1:0] {
        OP_RESET    = 2'b00,
        OP_RUNTEST  = 2'b01,
        OP_SHIFT_IR = 2'b10,
        OP_SHIFT_DR = 2'b11
    } jtag_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESP
    } jtag_state_e;

    localparam int SEQ_W = 16;

    // TMS patterns are stored LSB-first: bit k is driven during TCK k.
    localparam int         RESET_LEN   = 6;
    localparam logic [5:0] RESET_TMS   = 6'b011111;
    localparam int         IR_PRE_LEN  = 4;
    localparam logic [3:0] IR_PRE_TMS  = 4'b0011;
    localparam int         DR_PRE_LEN  = 3;
    localparam logic [2:0] DR_PRE_TMS  = 3'b001;
    localparam int         POST_LEN    = 2;
    localparam logic [1:0] POST_TMS    = 2'b01;

    function automatic logic is_shift_op(input jtag_op_e op);
        return (op == OP_SHIFT_IR) || (op == OP_SHIFT_DR);
    endfunction

    function automatic logic [SEQ_W-1:0] pre_len(input jtag_op_e op);
        logic [SEQ_W-1:0] n;
        case (op)
            OP_SHIFT_IR: n = SEQ_W'(IR_PRE_LEN);
            OP_SHIFT_DR: n = SEQ_W'(DR_PRE_LEN);
            default:     n = '0;
        endcase
        return n;
    endfunction

    // TMS level for TCK k of a command; len is the effective shift/run length.
    function automatic logic tms_at(input jtag_op_e op, input logic [SEQ_W-1:0] k,
                                    input logic [SEQ_W-1:0] len);
        logic [SEQ_W-1:0] pre;
        logic [SEQ_W-1:0] mask;
        logic             tms;
        pre  = pre_len(op);
        mask = SEQ_W'(1) << k;
        tms  = 1'b0;
        case (op)
            OP_RESET:   tms = |(SEQ_W'(RESET_TMS) & mask);
            OP_RUNTEST: tms = 1'b0;
            default: begin
                if (k < pre)
                    tms = |(((op == OP_SHIFT_IR) ? SEQ_W'(IR_PRE_TMS) : SEQ_W'(DR_PRE_TMS)) & mask);
                else if (k < pre + len)
                    tms = (k == pre + len - SEQ_W'(1));
                else
                    tms = |(SEQ_W'(POST_TMS) & (SEQ_W'(1) << (k - pre - len)));
            end
        endcase
        return tms;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// rtl/jtag_tck_gen.sv - divided TCK generator with one-cycle rise/fall strobes
module jtag_tck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic en,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam int               DIV_W   = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV);

    logic [DIV_W-1:0] cnt_q;
    logic             phase_end;

    // Strobes are high in the cycle before TCK changes, so the edge that moves
    // TCK is also the edge that updates TMS/TDI or captures TDO.
    assign phase_end = en && (cnt_q == DIV_MAX);
    assign tck_rise  = phase_end && !tck;
    assign tck_fall  = phase_end && tck;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !en) begin
            cnt_q <= '0;
            tck   <= 1'b0;
        end else if (phase_end) begin
            cnt_q <= '0;
            tck   <= ~tck;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/jtag_host_engine.sv
// rtl/jtag_host_engine.sv - JTAG initiator: IR/DR scan, TAP reset and run-test over valid/ready
module jtag_host_engine
    import jtag_host_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int LEN_W   = 7,
    parameter int CLK_DIV = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_tdi,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_tdo,
    output logic              busy,
    output logic              jtag_tck,
    output logic              jtag_tms,
    output logic              jtag_tdi,
    output logic              jtag_trst_n,
    input  logic              jtag_tdo
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    jtag_state_e       state_q, state_d;
    jtag_op_e          op_q, cmd_op_e;
    logic [SEQ_W-1:0]  len_q, pre_q, total_q, idx_q, idx_next;
    logic [SEQ_W-1:0]  cmd_len_eff, cmd_total;
    logic [DATA_W-1:0] tdi_sr_q;
    logic [IDX_W-1:0]  bit_idx;
    logic              tdo_ff;
    logic              tck_rise, tck_fall;
    logic              seq_done, cur_is_shift, next_is_shift;

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .en       (busy),
        .tck      (jtag_tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q == ST_RUN);

    // Effective length and total TCK count of the command being offered.
    always_comb begin
        cmd_op_e    = jtag_op_e'(cmd_op);
        cmd_len_eff = SEQ_W'(cmd_len);
        if (is_shift_op(cmd_op_e)) begin
            if (cmd_len_eff == '0)
                cmd_len_eff = SEQ_W'(1);
            else if (cmd_len_eff > SEQ_W'(DATA_W))
                cmd_len_eff = SEQ_W'(DATA_W);
        end
        case (cmd_op_e)
            OP_RESET:   cmd_total = SEQ_W'(RESET_LEN);
            OP_RUNTEST: cmd_total = cmd_len_eff;
            default:    cmd_total = cmd_len_eff + pre_len(cmd_op_e) + SEQ_W'(POST_LEN);
        endcase
    end

    always_comb begin
        idx_next      = idx_q + SEQ_W'(1);
        seq_done      = tck_fall && (idx_next == total_q);
        cur_is_shift  = is_shift_op(op_q) && (idx_q >= pre_q) && (idx_q < pre_q + len_q);
        next_is_shift = is_shift_op(op_q) && (idx_next >= pre_q) && (idx_next < pre_q + len_q);
        bit_idx       = IDX_W'(idx_q - pre_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = (cmd_total == '0) ? ST_RESP : ST_RUN;
            ST_RUN:  if (seq_done)  state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_RESET;
            len_q       <= '0;
            pre_q       <= '0;
            total_q     <= '0;
            idx_q       <= '0;
            tdi_sr_q    <= '0;
            rsp_tdo     <= '0;
            tdo_ff      <= 1'b0;
            jtag_tms    <= 1'b1;
            jtag_tdi    <= 1'b0;
            jtag_trst_n <= 1'b1;
        end else begin
            state_q <= state_d;
            tdo_ff  <= jtag_tdo;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op_e;
                        len_q    <= cmd_len_eff;
                        pre_q    <= pre_len(cmd_op_e);
                        total_q  <= cmd_total;
                        idx_q    <= '0;
                        tdi_sr_q <= cmd_tdi;
                        rsp_tdo  <= '0;
                        jtag_tdi <= 1'b0;
                        if (cmd_total != '0) begin
                            jtag_tms    <= tms_at(cmd_op_e, '0, cmd_len_eff);
                            jtag_trst_n <= (cmd_op_e != OP_RESET);
                        end
                    end
                end
                ST_RUN: begin
                    if (tck_rise && cur_is_shift)
                        rsp_tdo[bit_idx] <= tdo_ff;
                    if (tck_fall) begin
                        idx_q <= idx_next;
                        if (seq_done) begin
                            jtag_tdi    <= 1'b0;
                            jtag_trst_n <= 1'b1;
                        end else begin
                            jtag_tms <= tms_at(op_q, idx_next, len_q);
                            if (next_is_shift) begin
                                jtag_tdi <= tdi_sr_q[0];
                                tdi_sr_q <= tdi_sr_q >> 1;
                            end else begin
                                jtag_tdi <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
